// File: rtl/lsu_access_ctrl.sv
// rtl/lsu_access_ctrl.sv - byte-addressed load/store to doubleword memory access controller
module lsu_access_ctrl #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_write,
    output logic            mem_read,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] merged_q, merged_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            accept;
    logic            misaligned;
    logic            out_of_range;
    logic [5:0]      shamt;
    logic [XLEN-1:0] lanes;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] size_mask;
    logic [XLEN-1:0] lane_mask;

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (req_addr >> 3) >= XLEN'(DEPTH);

    // Byte lane offset within the doubleword, little-endian
    assign shamt = {addr_q[2:0], 3'b000};
    assign lanes = mem_rdata >> shamt;

    always_comb begin
        ext       = lanes;
        size_mask = '1;
        case (size_q)
            2'b00: begin
                ext       = uns_q ? {{(XLEN-8){1'b0}}, lanes[7:0]}
                                  : {{(XLEN-8){lanes[7]}}, lanes[7:0]};
                size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            2'b01: begin
                ext       = uns_q ? {{(XLEN-16){1'b0}}, lanes[15:0]}
                                  : {{(XLEN-16){lanes[15]}}, lanes[15:0]};
                size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            2'b10: begin
                ext       = uns_q ? {{(XLEN-32){1'b0}}, lanes[31:0]}
                                  : {{(XLEN-32){lanes[31]}}, lanes[31:0]};
                size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            end
            default: begin
                ext       = lanes;
                size_mask = '1;
            end
        endcase
    end

    assign lane_mask = size_mask << shamt;

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        uns_d    = uns_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    merged_d = req_wdata;
                    rdata_d  = '0;
                    err_d    = misaligned || out_of_range;
                    if (misaligned || out_of_range) state_d = RESP;
                    else if (!req_store)            state_d = RD;
                    else if (req_size == 2'b11)     state_d = WR;
                    else                            state_d = RMW_RD;
                end
            end
            RD: begin
                rdata_d = ext;
                state_d = RESP;
            end
            RMW_RD: begin
                merged_d = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
                state_d  = WR;
            end
            WR: begin
                rdata_d = '0;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            size_q   <= '0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_read   = (state_q == RD) || (state_q == RMW_RD);
    // Gated by rst_n so that a reset landing on the WR cycle cancels the write
    assign mem_write  = (state_q == WR) && rst_n;
    assign mem_wdata  = (state_q == WR) ? merged_q : '0;
    assign mem_addr   = (state_q == IDLE) ? '0 : {3'b000, addr_q[XLEN-1:3]};

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// tb/tb_lsu_access_ctrl.sv - directed and random checks of lsu_access_ctrl against a byte-level model
module tb_lsu_access_ctrl;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic [63:0] mem [0:DEPTH-1];
    logic [7:0]  ref_b [0:DEPTH*8-1];

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [63:0] last_wdata = '0;
    logic [63:0] last_waddr = '0;

    lsu_access_ctrl #(.XLEN(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 64'(DEPTH)) ? mem[mem_addr[4:0]] : 64'd0;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 64'(DEPTH)) mem[mem_addr[4:0]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_read) rd_cnt = rd_cnt + 1;
        if (mem_write) begin
            wr_cnt = wr_cnt + 1;
            last_wdata = mem_wdata;
            last_waddr = mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_entry(input int idx);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v |= 64'(ref_b[idx*8+i]) << (8*i);
        return v;
    endfunction

    task automatic set_entry(input int idx, input logic [63:0] v);
        mem[idx] = v;
        for (int i = 0; i < 8; i++) ref_b[idx*8+i] = v[8*i +: 8];
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [63:0] a, input logic [63:0] wd, input int hold);
        int          n;
        int          lat;
        int          exp_lat, exp_rd, exp_wr;
        logic        exp_e;
        logic [63:0] exp_d;
        logic [63:0] held;
        n       = 1 << sz;
        exp_e   = ((a & 64'(n-1)) != 0) || ((a >> 3) >= 64'(DEPTH));
        exp_d   = '0;
        if (!exp_e && !st) begin
            for (int i = 0; i < n; i++) exp_d |= 64'(ref_b[int'(a)+i]) << (8*i);
            if (!un && n < 8 && exp_d[8*n-1]) exp_d |= ~((64'd1 << (8*n)) - 64'd1);
        end
        exp_lat = exp_e ? 1 : (!st || n == 8) ? 2 : 3;
        exp_rd  = (exp_e || (st && n == 8)) ? 0 : 1;
        exp_wr  = (!exp_e && st) ? 1 : 0;

        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        lat = 0;
        while (!req_ready && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        rd_cnt = 0; wr_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_ready_after_accept", 64'(req_ready), 64'd0);
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("resp_err", 64'(resp_err), 64'(exp_e));
        chk("resp_rdata", resp_rdata, exp_d);
        held = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, held);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("mem_read_cycles", 64'(rd_cnt), 64'(exp_rd));
        chk("mem_write_cycles", 64'(wr_cnt), 64'(exp_wr));
        chk("idle_after_resp", 64'(req_ready), 64'd1);
        if (st && !exp_e) begin
            for (int i = 0; i < n; i++) ref_b[int'(a)+i] = wd[8*i +: 8];
            chk("store_wdata", last_wdata, ref_entry(int'(a >> 3)));
            chk("store_waddr", last_waddr, a >> 3);
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [63:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) set_entry(i, {$urandom, $urandom});
        set_entry(0, 64'd5);
        set_entry(1, 64'd5);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        do_req(1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 0);
        do_req(1'b1, 2'b00, 1'b0, 64'h9, 64'hAB, 0);
        chk("byte_merge", last_wdata, 64'h0000_0000_0000_AB05);
        do_req(1'b0, 2'b11, 1'b0, 64'h8, 64'h0, 0);
        do_req(1'b1, 2'b01, 1'b0, 64'h16, 64'h8001, 0);
        do_req(1'b0, 2'b01, 1'b0, 64'h16, 64'h0, 0);
        do_req(1'b0, 2'b01, 1'b1, 64'h16, 64'h0, 0);
        do_req(1'b0, 2'b10, 1'b0, 64'h6, 64'h0, 0);
        do_req(1'b1, 2'b11, 1'b0, 64'h100, 64'h1234, 0);
        do_req(1'b0, 2'b10, 1'b0, 64'h10, 64'h0, 3);
        do_req(1'b0, 2'b00, 1'b1, 64'hF8, 64'h0, 0);

        // Reset landing on the WR cycle of a byte store
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 64'h21; req_wdata = 64'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("wr_state_reached", 64'(mem_write), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("wr_gated_by_reset", 64'(mem_write), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("reset_abort_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        chk("reset_abort_no_resp", 64'(resp_valid), 64'd0);
        chk("reset_abort_ready2", 64'(req_ready), 64'd1);
        chk("reset_abort_mem", mem[4], ref_entry(4));

        for (int t = 0; t < 200; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, DEPTH*8 + 23));
            if ($urandom_range(0, 3) != 0) a &= ~64'((1 << sz) - 1);
            if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   {$urandom, $urandom}, $urandom_range(0, 2));
        end

        for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_entry(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
